// File: rtl/mux_4x1_pkg.sv
// Shared definitions for the 4:1 operand/result selector.
// Holds the default data width and the select encoding.
package mux_4x1_pkg;

    localparam int MUX_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        SEL_F0 = 2'd0,
        SEL_F1 = 2'd1,
        SEL_F2 = 2'd2,
        SEL_F3 = 2'd3
    } sel_e;

endpackage : mux_4x1_pkg

// File: rtl/mux_4x1_comb.sv
// Purely combinational one-of-four word selector.
// An unknown select propagates as X instead of being masked to a fixed input.
module mux_4x1_comb
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] f0,
    input  logic [WIDTH-1:0] f1,
    input  logic [WIDTH-1:0] f2,
    input  logic [WIDTH-1:0] f3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    sel_e w_sel;

    assign w_sel = sel_e'(s);

    // Conditional operators rather than a case statement so an X select yields X.
    assign y = (w_sel == SEL_F0) ? f0 :
               (w_sel == SEL_F1) ? f1 :
               (w_sel == SEL_F2) ? f2 : f3;

endmodule : mux_4x1_comb

// File: rtl/mux_4x1.sv
// 4:1 selector with a combinational output and an enable-gated pipeline register
// that captures the selected word together with its select value.
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] f0,
    input  logic [WIDTH-1:0] f1,
    input  logic [WIDTH-1:0] f2,
    input  logic [WIDTH-1:0] f3,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       s_q
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;
    logic [1:0]       r_s_q;

    mux_4x1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .f0 (f0),
        .f1 (f1),
        .f2 (f2),
        .f3 (f3),
        .s  (s),
        .y  (w_y)
    );

    // Reset wins over enable so a reset inside an enable burst still clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
            r_s_q <= '0;
        end else if (en) begin
            r_y_q <= w_y;
            r_s_q <= s;
        end
    end

    assign y   = w_y;
    assign y_q = r_y_q;
    assign s_q = r_s_q;

endmodule : mux_4x1

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: vector table plus hand-written corner sequences,
// registered outputs checked through an expected-value queue.
module tb_mux_4x1;

    logic        clk;
    logic        rst;
    logic [31:0] f0, f1, f2, f3;
    logic [1:0]  s;
    logic        en;
    logic [31:0] y, y_q;
    logic [1:0]  s_q;

    logic        rst8;
    logic [7:0]  g0, g1, g2, g3;
    logic [1:0]  s8;
    logic        en8;
    logic [7:0]  y8, y_q8;
    logic [1:0]  s_q8;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] y;
        logic [1:0]  s;
    } reg_exp_t;

    reg_exp_t    sb_q[$];
    logic [31:0] m_yq;
    logic [1:0]  m_sq;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  s;
        logic [31:0] f0, f1, f2, f3;
        logic [31:0] exp_y;
    } vec_t;

    mux_4x1 #(.WIDTH(32)) u_dut (
        .clk (clk), .rst (rst),
        .f0 (f0), .f1 (f1), .f2 (f2), .f3 (f3),
        .s (s), .en (en),
        .y (y), .y_q (y_q), .s_q (s_q)
    );

    mux_4x1 #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst8),
        .f0 (g0), .f1 (g1), .f2 (g2), .f3 (g3),
        .s (s8), .en (en8),
        .y (y8), .y_q (y_q8), .s_q (s_q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mux(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c,
                                            input logic [31:0] d);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    // Push the register expectation for the coming edge, clock it, then pop and compare.
    task automatic step(input string name);
        reg_exp_t e;
        if (rst) begin
            m_yq = '0;
            m_sq = '0;
        end else if (en) begin
            m_yq = ref_mux(s, f0, f1, f2, f3);
            m_sq = s;
        end
        e.y = m_yq;
        e.s = m_sq;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, ".y_q"}, y_q, e.y);
            chk({name, ".s_q"}, {30'd0, s_q}, {30'd0, e.s});
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd0, 32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 32'd10, 32'd11, 32'd12, 32'd13, 32'd11};
        vecs[2] = '{1'b0, 1'b0, 2'd2, 32'd10, 32'd11, 32'd12, 32'd13, 32'd12};
        vecs[3] = '{1'b0, 1'b1, 2'd3, 32'd10, 32'd11, 32'd12, 32'd13, 32'd13};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'd10, 32'd11, 32'd12, 32'd13, 32'd11};
        vecs[5] = '{1'b0, 1'b1, 2'd2, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF};
        vecs[7] = '{1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h8000_0001, 32'h8000_0001};

        rst = 1'b1; en = 1'b0; s = 2'd0;
        f0 = 32'd10; f1 = 32'd11; f2 = 32'd12; f3 = 32'd13;
        rst8 = 1'b1; en8 = 1'b0; s8 = 2'd0;
        g0 = 8'h01; g1 = 8'h02; g2 = 8'h03; g3 = 8'h04;
        m_yq = '0; m_sq = '0;

        // Reset state
        @(negedge clk);
        step("reset");
        chk("reset.y", y, 32'd10);

        // Combinational stepping of the select, 10 time units apart
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1;
            chk($sformatf("walk%0d.y", i), y, 32'd10 + 32'(i));
            #9;
        end

        // Vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; s = vecs[i].s;
            f0 = vecs[i].f0; f1 = vecs[i].f1; f2 = vecs[i].f2; f3 = vecs[i].f3;
            #1;
            chk($sformatf("vec%0d.y", i), y, vecs[i].exp_y);
            step($sformatf("vec%0d", i));
        end

        // Data change with select held: y follows at once, y_q waits for an enabled edge
        @(negedge clk);
        rst = 1'b0; en = 1'b0; s = 2'd2;
        f0 = 32'd10; f1 = 32'd11; f2 = 32'd12; f3 = 32'd13;
        #1;
        chk("follow.y_before", y, 32'd12);
        f2 = 32'hFFFF_FFFF;
        #1;
        chk("follow.y_after", y, 32'hFFFF_FFFF);
        chk("follow.y_q_held", y_q, m_yq);
        step("follow_hold");
        f2 = 32'd12;

        // Reset held two edges while enabled
        @(negedge clk);
        rst = 1'b1; en = 1'b1; s = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rst%0d.y", i), y, 32'd13);
            step($sformatf("rst%0d", i));
            chk($sformatf("rst%0d.y_post", i), y, 32'd13);
            @(negedge clk);
        end

        // Release, load once, then hold
        rst = 1'b0; en = 1'b1; s = 2'd1;
        step("load1");
        chk("load1.y_q_lit", y_q, 32'd11);
        @(negedge clk);
        en = 1'b0; s = 2'd3;
        #1;
        chk("hold.y", y, 32'd13);
        step("hold");
        chk("hold.y_q_lit", y_q, 32'd11);

        // Unknown select must not resolve to a valid word (only observable in 4-state sim)
        @(negedge clk);
        s = 2'bx;
        #1;
        if ($isunknown(s)) begin
            n_checks++;
            if (!$isunknown(y)) begin
                n_errors++;
                $display("FAIL xsel.y: got %h, expected X", y);
            end
        end
        s = 2'd0;

        // Narrow instance
        @(negedge clk);
        rst8 = 1'b0; en8 = 1'b1; s8 = 2'd3; g3 = 8'hA5;
        #1;
        chk("w8.y", {24'd0, y8}, 32'h0000_00A5);
        chk("w8.y_q_pre", {24'd0, y_q8}, 32'h0);
        @(posedge clk);
        #1;
        chk("w8.y_q", {24'd0, y_q8}, 32'h0000_00A5);
        chk("w8.s_q", {30'd0, s_q8}, 32'd3);
        @(negedge clk);
        s8 = 2'd1; en8 = 1'b0;
        #1;
        chk("w8.y_s1", {24'd0, y8}, 32'h0000_0002);
        @(posedge clk);
        #1;
        chk("w8.y_q_hold", {24'd0, y_q8}, 32'h0000_00A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_4x1
